axifloat_cmd_sequencer: RTL and testbench
=========================================

AXIFLOAT_CMD_SEQUENCER -- requirements
Module: axifloat_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter C_BASE_ADDR, default 32'h0000_0000, the AXIFloat register-bank base address.
REQ-002 The block SHALL have parameter C_POLL_LIMIT, default 255, the maximum number of status reads per command before timeout.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 ACLK  in  1  the only clock; all logic is on the rising edge.
REQ-005 ARESET  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-008 cmd_op  in  2  float opcode.
REQ-009 cmd_a  in  32  operand A.
REQ-010 cmd_b  in  32  operand B.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  result consumed.
REQ-013 rsp_data  out  32  result word.
REQ-014 rsp_err  out  1  bus error or poll timeout.
REQ-015 M_AXI_AWADDR  out  32; M_AXI_AWVALID  out  1; M_AXI_AWREADY  in  1: AXI4-Lite write address channel.
REQ-016 M_AXI_WDATA  out  32; M_AXI_WSTRB  out  4, constant 4'hF; M_AXI_WVALID  out  1; M_AXI_WREADY  in  1: write data channel.
REQ-017 M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1: write response channel.
REQ-018 M_AXI_ARADDR  out  32; M_AXI_ARVALID  out  1; M_AXI_ARREADY  in  1: read address channel.
REQ-019 M_AXI_RDATA  in  32; M_AXI_RRESP  in  2; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1: read data channel.

Function
REQ-020 The FSM SHALL use the states IDLE, WR_A, WR_B, WR_CTRL, POLL_AR, POLL_R, RES_AR, RES_R and RSP.
- cmd_ready is high only in IDLE.
- On the cmd_valid&cmd_ready cycle, cmd_op, cmd_a and cmd_b are registered and the FSM moves to WR_A.
REQ-021 WR_A, WR_B and WR_CTRL SHALL each perform one AXI4-Lite write to C_BASE_ADDR+0x0, +0x4 and +0x8 respectively.
- WR_A and WR_B write the registered operand.
- WR_CTRL writes {29'b0, op[1:0], 1'b1}: start bit at bit 0, opcode at bits [2:1].
REQ-022 Within a write state:
- AWVALID and WVALID SHALL assert on state entry.
- Each SHALL deassert independently on its own handshake.
- BREADY SHALL be high once both handshakes have completed.
- The state SHALL advance on the cycle after BVALID&BREADY.
REQ-023 POLL_AR/POLL_R SHALL read C_BASE_ADDR+0x8 (ARVALID until ARREADY, then RREADY=1 until RVALID).
- If RDATA[31]=1, go to RES_AR.
- Otherwise increment the poll counter and return to POLL_AR.
REQ-024 RES_AR/RES_R SHALL read C_BASE_ADDR+0xC, capture RDATA into rsp_data, and go to RSP.
REQ-025 In RSP, rsp_valid SHALL be high and held stable until rsp_ready.
- On the cycle after rsp_valid&rsp_ready, the FSM returns to IDLE.
- rsp_valid&rsp_ready and a new cmd_valid in the same cycle SHALL NOT overlap: the command is accepted no earlier than the following cycle.
REQ-026 Any BRESP or RRESP other than 2'b00 SHALL abort the sequence directly to RSP with rsp_err=1 and rsp_data=32'h0000_0000.
REQ-027 If the poll counter reaches C_POLL_LIMIT without done, the block SHALL go to RSP with rsp_err=1 and rsp_data=32'h0000_0000.
REQ-028 The poll counter SHALL be 16 bits wide, cleared on command accept, and saturating.
REQ-029 Exactly one AXI transaction SHALL be outstanding at any time, and no VALID SHALL drop before its READY.

Reset
REQ-030 While ARESET=1, the following SHALL be forced immediately, regardless of clock:
- FSM in IDLE.
- cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
- All AXI VALID/READY outputs 0, and addresses and WDATA 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no response.
REQ-032 cmd_ready SHALL rise on the first rising edge after ARESET deasserts.

Verification
REQ-033 Command with op=2, A=0x3F800000, B=0x40000000; slave sets done on the 3rd poll and result 0x40400000 -> writes 0x3F800000@0x0, 0x40000000@0x4, 0x00000005@0x8; exactly 3 reads of 0x8; rsp_data=0x40400000 with rsp_err=0.
REQ-034 AWREADY delayed 4 cycles relative to WREADY on every write -> WVALID drops after its own handshake, AWVALID is held, and the sequence completes correctly.
REQ-035 BRESP=2'b10 on the write to 0x4 -> no write to 0x8 occurs; rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-036 Done never set with C_POLL_LIMIT=8 -> exactly 8 status reads; rsp_err=1.
REQ-037 rsp_ready held low for 10 cycles -> rsp_valid and rsp_data remain stable and cmd_ready stays 0 until the handshake completes.
REQ-038 ARESET pulsed during POLL_R -> all outputs return to their reset values in the same cycle, and the next command executes normally.

Source files
------------

// File: rtl/axifloat_cmd_sequencer.sv
// Turns one float command into an AXI4-Lite sequence on an AXIFloat register bank:
// write operands and control, poll status until done, read the result.
module axifloat_cmd_sequencer #(
   parameter logic [31:0] C_BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned C_POLL_LIMIT = 255
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] M_AXI_AWADDR,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [31:0] M_AXI_ARADDR,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);

   localparam int unsigned CNT_W      = 16;
   localparam logic [CNT_W-1:0] POLL_LIMIT = CNT_W'(C_POLL_LIMIT);

   typedef enum logic [3:0] {
      IDLE, WR_A, WR_B, WR_CTRL, POLL_AR, POLL_R, RES_AR, RES_R, RSP
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [31:0]       a_q, a_d, b_q, b_d;
   logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d, poll_inc;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [31:0]       rsp_data_q, rsp_data_d;
   logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic              arvalid_q, arvalid_d, rready_q, rready_d;
   logic [31:0]       awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      poll_cnt_d = poll_cnt_q;
      rsp_err_d  = rsp_err_q;
      rsp_data_d = rsp_data_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      bready_d   = bready_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      araddr_d   = araddr_q;
      poll_inc   = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d       = cmd_op;
               a_d        = cmd_a;
               b_d        = cmd_b;
               poll_cnt_d = '0;
               state_d    = WR_A;
               awvalid_d  = 1'b1;
               wvalid_d   = 1'b1;
               awaddr_d   = C_BASE_ADDR;
               wdata_d    = cmd_a;
            end
         end
         WR_A, WR_B, WR_CTRL: begin
            // address and data channels retire independently; B accepted once both are done
            if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
            bready_d = !awvalid_d && !wvalid_d;
            if (bready_q && M_AXI_BVALID) begin
               bready_d = 1'b0;
               if (M_AXI_BRESP != 2'b00) begin
                  state_d    = RSP;
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
               end else begin
                  case (state_q)
                     WR_A: begin
                        state_d   = WR_B;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = C_BASE_ADDR + 32'h4;
                        wdata_d   = b_q;
                     end
                     WR_B: begin
                        state_d   = WR_CTRL;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = C_BASE_ADDR + 32'h8;
                        wdata_d   = {29'b0, op_q, 1'b1};
                     end
                     default: begin
                        state_d  = POLL_AR;
                        araddr_d = C_BASE_ADDR + 32'h8;
                     end
                  endcase
               end
            end
         end
         POLL_AR: if (M_AXI_ARREADY) state_d = POLL_R;
         POLL_R: begin
            if (M_AXI_RVALID) begin
               if (M_AXI_RRESP != 2'b00) begin
                  state_d    = RSP;
                  rsp_err_d  = 1'b1;
                  rsp_data_d = '0;
               end else if (M_AXI_RDATA[31]) begin
                  state_d  = RES_AR;
                  araddr_d = C_BASE_ADDR + 32'hC;
               end else begin
                  poll_cnt_d = poll_inc;
                  if (poll_inc >= POLL_LIMIT) begin
                     state_d    = RSP;
                     rsp_err_d  = 1'b1;
                     rsp_data_d = '0;
                  end else begin
                     state_d = POLL_AR;
                  end
               end
            end
         end
         RES_AR: if (M_AXI_ARREADY) state_d = RES_R;
         RES_R: begin
            if (M_AXI_RVALID) begin
               state_d    = RSP;
               rsp_err_d  = (M_AXI_RRESP != 2'b00);
               rsp_data_d = (M_AXI_RRESP != 2'b00) ? 32'h0 : M_AXI_RDATA;
            end
         end
         RSP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // handshake outputs that depend only on the state being entered
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RSP);
      arvalid_d   = (state_d == POLL_AR) || (state_d == RES_AR);
      rready_d    = (state_d == POLL_R)  || (state_d == RES_R);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         poll_cnt_q  <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         araddr_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         poll_cnt_q  <= poll_cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         araddr_q    <= araddr_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_err       = rsp_err_q;
   assign rsp_data      = rsp_data_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axifloat_cmd_sequencer.sv
// Directed bench for axifloat_cmd_sequencer against a behavioural AXI4-Lite register-bank slave.
module tb_axifloat_cmd_sequencer;

   localparam int unsigned POLL_LIMIT = 8;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b, rsp_data;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   int total = 0;
   int bad   = 0;

   // slave knobs and observation log
   int          aw_lag, done_on;
   logic [31:0] result_word, bad_addr;
   logic        bad_en;
   int          wr_n, poll_reads, res_reads, ctrl_writes, split_seen, viol;
   logic [31:0] wr_addr [0:7];
   logic [31:0] wr_data [0:7];

   axifloat_cmd_sequencer #(.C_BASE_ADDR(32'h0000_0000), .C_POLL_LIMIT(POLL_LIMIT)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Slave acts on the falling edge; *_hs flags predict the handshakes seen at the next rising edge.
   initial begin
      logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, ar_got;
      logic pv_aw, pv_w, pv_ar;
      logic [31:0] aw_a, w_d, ar_a;
      int aw_wait;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_got = 0; w_got = 0; ar_got = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
      aw_a = 0; w_d = 0; ar_a = 0; aw_wait = 0;
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_got = 0; w_got = 0; ar_got = 0; pv_aw = 0; pv_w = 0; pv_ar = 0;
            aw_wait = aw_lag;
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
         end else begin
            if ((pv_aw && !aw_hs && !M_AXI_AWVALID) || (pv_w && !w_hs && !M_AXI_WVALID) ||
                (pv_ar && !ar_hs && !M_AXI_ARVALID)) viol++;
            if ((M_AXI_ARVALID || M_AXI_RREADY) && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY)) viol++;
            if (M_AXI_AWVALID && !M_AXI_WVALID) split_seen++;
            pv_aw = M_AXI_AWVALID; pv_w = M_AXI_WVALID; pv_ar = M_AXI_ARVALID;
            if (aw_hs) begin M_AXI_AWREADY = 0; aw_got = 1; end
            if (w_hs)  begin M_AXI_WREADY = 0;  w_got = 1;  end
            if (b_hs)  M_AXI_BVALID = 0;
            if (ar_hs) begin M_AXI_ARREADY = 0; ar_got = 1; end
            if (r_hs)  M_AXI_RVALID = 0;
            if (M_AXI_WVALID && !w_got && !M_AXI_WREADY) begin M_AXI_WREADY = 1; w_d = M_AXI_WDATA; end
            if (M_AXI_AWVALID && !aw_got && !M_AXI_AWREADY) begin
               if (aw_wait > 0) aw_wait--;
               else begin M_AXI_AWREADY = 1; aw_a = M_AXI_AWADDR; end
            end
            if (aw_got && w_got && !M_AXI_BVALID) begin
               M_AXI_BVALID = 1;
               M_AXI_BRESP  = (bad_en && aw_a == bad_addr) ? 2'b10 : 2'b00;
               if (wr_n < 8) begin wr_addr[wr_n] = aw_a; wr_data[wr_n] = w_d; end
               wr_n++;
               if (aw_a == 32'h8) ctrl_writes++;
               aw_got = 0; w_got = 0; aw_wait = aw_lag;
            end
            if (M_AXI_ARVALID && !ar_got && !M_AXI_ARREADY) begin M_AXI_ARREADY = 1; ar_a = M_AXI_ARADDR; end
            if (ar_got && !M_AXI_RVALID) begin
               M_AXI_RVALID = 1; M_AXI_RRESP = 2'b00; ar_got = 0;
               if (ar_a == 32'h8) begin
                  poll_reads++;
                  M_AXI_RDATA = (done_on > 0 && poll_reads >= done_on) ? 32'h8000_0000 : 32'h0;
               end else begin
                  res_reads++;
                  M_AXI_RDATA = result_word;
               end
            end
            aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
            w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
            b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
            ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
            r_hs  = M_AXI_RVALID  && M_AXI_RREADY;
         end
      end
   end

   task automatic setup(input int lag, input int don, input logic [31:0] res,
                        input logic ben, input logic [31:0] baddr);
      aw_lag = lag; done_on = don; result_word = res; bad_en = ben; bad_addr = baddr;
      wr_n = 0; poll_reads = 0; res_reads = 0; ctrl_writes = 0; split_seen = 0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
      if (!cmd_ready) check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
      @(negedge ACLK);
      cmd_valid = 0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 2000) begin @(negedge ACLK); n++; end
      check_eq("rsp_valid_seen", 32'(rsp_valid), 32'd1);
   endtask

   task automatic finish_rsp();
      rsp_ready = 1;
      @(negedge ACLK);
      rsp_ready = 0;
      check_eq("rsp_valid_drop", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int n;
      cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0; viol = 0;
      ARESET = 1;
      setup(0, 0, 32'h0, 1'b0, 32'h0);
      repeat (3) @(negedge ACLK);

      // reset values and first-edge cmd_ready
      check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_valids", {29'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 32'd0);
      check_eq("rst_readys", {30'b0, M_AXI_BREADY, M_AXI_RREADY}, 32'd0);
      check_eq("rst_awaddr", M_AXI_AWADDR, 32'h0);
      check_eq("wstrb", 32'(M_AXI_WSTRB), 32'hF);
      #2 ARESET = 0;
      #1 check_eq("cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
      @(negedge ACLK);
      check_eq("cmd_ready_after_edge", 32'(cmd_ready), 32'd1);

      // basic add-style command, done on third poll, then response back-pressure
      setup(0, 3, 32'h4040_0000, 1'b0, 32'h0);
      run_cmd(2'd2, 32'h3F80_0000, 32'h4000_0000);
      wait_rsp();
      check_eq("t1_wr_n", 32'(wr_n), 32'd3);
      check_eq("t1_wa0", wr_addr[0], 32'h0);
      check_eq("t1_wd0", wr_data[0], 32'h3F80_0000);
      check_eq("t1_wa1", wr_addr[1], 32'h4);
      check_eq("t1_wd1", wr_data[1], 32'h4000_0000);
      check_eq("t1_wa2", wr_addr[2], 32'h8);
      check_eq("t1_wd2", wr_data[2], 32'h0000_0005);
      check_eq("t1_polls", 32'(poll_reads), 32'd3);
      check_eq("t1_res_reads", 32'(res_reads), 32'd1);
      check_eq("t1_err", 32'(rsp_err), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         check_eq("hold_valid", 32'(rsp_valid), 32'd1);
         check_eq("hold_data", rsp_data, 32'h4040_0000);
         check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      finish_rsp();

      // AWREADY lags WREADY on every write
      setup(4, 1, 32'hCAFE_F00D, 1'b0, 32'h0);
      run_cmd(2'd1, 32'h1111_1111, 32'h2222_2222);
      wait_rsp();
      check_eq("t2_wr_n", 32'(wr_n), 32'd3);
      check_eq("t2_wd0", wr_data[0], 32'h1111_1111);
      check_eq("t2_wd1", wr_data[1], 32'h2222_2222);
      check_eq("t2_wd2", wr_data[2], 32'h0000_0003);
      check_eq("t2_split", 32'(split_seen > 0), 32'd1);
      check_eq("t2_polls", 32'(poll_reads), 32'd1);
      check_eq("t2_data", rsp_data, 32'hCAFE_F00D);
      check_eq("t2_err", 32'(rsp_err), 32'd0);
      finish_rsp();

      // slave error on the operand-B write aborts before control write
      setup(0, 1, 32'h5555_5555, 1'b1, 32'h4);
      run_cmd(2'd0, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
      wait_rsp();
      check_eq("t3_wr_n", 32'(wr_n), 32'd2);
      check_eq("t3_ctrl_writes", 32'(ctrl_writes), 32'd0);
      check_eq("t3_polls", 32'(poll_reads), 32'd0);
      check_eq("t3_err", 32'(rsp_err), 32'd1);
      check_eq("t3_data", rsp_data, 32'h0);
      finish_rsp();

      // done never set: poll limit reached
      setup(0, 0, 32'h7777_7777, 1'b0, 32'h0);
      run_cmd(2'd3, 32'h1, 32'h2);
      wait_rsp();
      check_eq("t4_polls", 32'(poll_reads), 32'(POLL_LIMIT));
      check_eq("t4_res_reads", 32'(res_reads), 32'd0);
      check_eq("t4_err", 32'(rsp_err), 32'd1);
      check_eq("t4_data", rsp_data, 32'h0);
      finish_rsp();

      // reset pulse while waiting on a status read
      setup(0, 0, 32'h0, 1'b0, 32'h0);
      run_cmd(2'd2, 32'h9, 32'hA);
      n = 0;
      while (!M_AXI_RREADY && n < 200) begin @(negedge ACLK); n++; end
      check_eq("t5_reached_poll_r", 32'(M_AXI_RREADY), 32'd1);
      #2 ARESET = 1;
      #1;
      check_eq("t5_rready", 32'(M_AXI_RREADY), 32'd0);
      check_eq("t5_arvalid", 32'(M_AXI_ARVALID), 32'd0);
      check_eq("t5_araddr", M_AXI_ARADDR, 32'h0);
      check_eq("t5_wdata", M_AXI_WDATA, 32'h0);
      check_eq("t5_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("t5_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
      @(negedge ACLK);
      @(negedge ACLK);
      #2 ARESET = 0;
      @(negedge ACLK);
      check_eq("t5_no_rsp", 32'(rsp_valid), 32'd0);
      setup(0, 2, 32'h1234_5678, 1'b0, 32'h0);
      run_cmd(2'd3, 32'h5, 32'h6);
      wait_rsp();
      check_eq("t6_wr_n", 32'(wr_n), 32'd3);
      check_eq("t6_wd0", wr_data[0], 32'h5);
      check_eq("t6_wd2", wr_data[2], 32'h0000_0007);
      check_eq("t6_polls", 32'(poll_reads), 32'd2);
      check_eq("t6_data", rsp_data, 32'h1234_5678);
      check_eq("t6_err", 32'(rsp_err), 32'd0);
      finish_rsp();

      check_eq("protocol_violations", 32'(viol), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
